decode_stage: RTL
=================

# decode_stage

Decode stage of the risky RV32I integer pipeline, one stage upstream of the ALU. Accepts fetched instructions over a valid/ready handshake. Reads the register file, selects operands, and translates opcode/funct fields into the ALU control encoding. Presents the result one cycle later through a registered valid/ready output.

## Interface
- No parameters.
- i_clk  in  1  clock; all state on rising edge
- i_rst_n  in  1  synchronous, active-low reset
- i_valid  in  1  upstream instruction valid
- o_ready  out  1  stage can accept this cycle (combinational)
- i_inst  in  32  instruction word
- i_pc  in  32  instruction address
- i_flush  in  1  discard held and incoming instruction
- o_rs1_addr, o_rs2_addr  out  5 each  register file read addresses, combinational from i_inst[19:15] / [24:20]
- i_rs1_data, i_rs2_data  in  32 each  register file read data, same cycle (asynchronous read, x0 reads 0)
- i_wb_en, i_wb_addr, i_wb_data  in  1/5/32  writeback port; used only with bypass enabled
- o_valid  out  1  decoded instruction valid
- i_ready  in  1  downstream accepts
- o_op_a, o_op_b  out  32 each  ALU operands
- o_sub  out  1  subtract / arithmetic right shift
- o_bool_op  out  2  00 xor, 10 or, 11 and
- o_op_sel  out  4  one-hot: [0] add, [1] reserved (always 0), [2] bool, [3] shift
- o_shift_dir  out  1  0 left, 1 right
- o_rd_addr  out  5  destination register
- o_rd_wen  out  1  write enable; 0 when rd==0 or illegal
- o_illegal  out  1  unsupported/illegal encoding

## Operation
- Accept when i_valid && o_ready; o_ready = !o_valid || i_ready.
- OP (0110011): op_a=rs1, op_b=rs2.
  - ADD/SUB: op_sel 0001, sub=funct7[5].
  - XOR/OR/AND: op_sel 0100, bool_op 00/10/11.
  - SLL/SRL/SRA: op_sel 1000, shift_dir=funct3[2], sub=funct7[5]. op_b = {27'b0, rs2[4:0]}; bit 5 of the ALU shift amount must never be set.
- OP-IMM (0010011): op_a=rs1, op_b=sign-extended I-imm; same mapping as OP.
  - ADDI: sub=0.
  - Shifts: op_b={27'b0, inst[24:20]}.
  - SRAI sets sub=1.
  - Shift funct7 other than 0000000/0100000: illegal.
- LUI: op_a=0, op_b={inst[31:12],12'b0}, add.
- AUIPC: op_a=i_pc, op_b=U-imm, add.
- The following are illegal:
  - SLT/SLTU/SLTI/SLTIU (no compare unit yet).
  - Every other opcode.
  - OP funct7 other than 0000000, or 0100000 for ADD/SUB/SRL/SRA only.
- Illegal: o_op_sel=0000, o_rd_wen=0, o_illegal=1, o_valid still asserted so the trap logic sees it.
- Hazards against in-flight older instructions belong to the hazard unit, not this block. Operands are captured at accept and not refreshed while stalled.

## Timing
- Latency 1: accept in cycle N, outputs valid from N+1.
- Full throughput when i_ready held high.
- Stall (o_valid && !i_ready): all outputs hold bit-stable, o_ready=0.
- Accept and drain in the same cycle: new instruction replaces old, no bubble.
- i_flush: next cycle o_valid=0. It overrides a simultaneous accept (input dropped) and a held instruction.
- Reset (also mid-stall): every output register 0, o_valid=0. o_ready=1 the cycle after reset.
- Only o_valid requires reset. Data registers also reset to 0 for deterministic verification.

## Configuration
- DECODE_WB_BYPASS_EN defined:
  - rs1 operand = i_wb_data when i_wb_en && i_wb_addr!=0 && i_wb_addr==rs1; same for rs2.
  - Applies to the shift mask after selection.
- Undefined: i_wb_* ignored, operands come straight from the register file.

## Structure
- risky_pkg holds:
  - opcode localparams.
  - op_sel bit indices (OP_ADD=0, OP_BOOL=2, OP_SHIFT=3).
  - bool_op encodings.
  - packed struct alu_ctrl_t {sub, bool_op, op_sel, shift_dir}.
- Sub-module decode_alu_ctrl: purely combinational inst -> alu_ctrl_t, imm select, illegal. The top holds the handshake, operand mux, bypass and output registers.

## Test plan
- ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7, i_ready=1 -> next cycle o_valid=1, op_a=5, op_b=7, op_sel=0001, sub=0, rd_addr=3, rd_wen=1.
- SRAI x5,x6,3 (0x40335293), rs1=0x80000000 -> op_sel=1000, shift_dir=1, sub=1, op_b=3. SRA with rs2=0x23 -> op_b=3.
- SLT x3,x1,x2 (0x0020A1B3) -> o_valid=1, illegal=1, op_sel=0000, rd_wen=0.
- Back-to-back issue then i_ready=0 for 3 cycles with i_valid=1 -> o_ready=0, outputs unchanged. i_ready=1 -> next instruction appears the following cycle, none lost or duplicated.
- i_flush coincident with an accept while stalled -> o_valid=0 next cycle. i_rst_n=0 mid-stall -> all outputs 0 next cycle.
- With DECODE_WB_BYPASS_EN: ADD x3,x1,x2, i_wb_en=1, wb_addr=1, wb_data=0x1234, regfile rs1=9 -> op_a=0x1234. wb_addr=0 -> no bypass. Without the macro -> op_a=9.

Source files
------------

// File: rtl/risky_pkg.sv
// rtl/risky_pkg.sv - Opcodes, ALU select indices and control types for the risky decode stage
package risky_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam int OP_ADD   = 0;
  localparam int OP_BOOL  = 2;
  localparam int OP_SHIFT = 3;

  localparam logic [1:0] BOOL_XOR = 2'b00;
  localparam logic [1:0] BOOL_OR  = 2'b10;
  localparam logic [1:0] BOOL_AND = 2'b11;

  typedef struct packed {
    logic       sub;
    logic [1:0] bool_op;
    logic [3:0] op_sel;
    logic       shift_dir;
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    SRC_A_RS1  = 2'd0,
    SRC_A_ZERO = 2'd1,
    SRC_A_PC   = 2'd2
  } src_a_t;

  typedef enum logic {
    SRC_B_RS2 = 1'b0,
    SRC_B_IMM = 1'b1
  } src_b_t;

endpackage

// File: rtl/decode_alu_ctrl.sv
// rtl/decode_alu_ctrl.sv - Combinational instruction to ALU control, operand source, immediate and illegal flag
module decode_alu_ctrl
  import risky_pkg::*;
(
  input  logic [31:0] inst,
  output alu_ctrl_t   ctrl,
  output src_a_t      src_a,
  output src_b_t      src_b,
  output logic [31:0] imm,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic       is_imm;
  logic       f7_base;
  logic       f7_alt;
  logic       unused_rd;

  assign opcode    = inst[6:0];
  assign funct3    = inst[14:12];
  assign funct7    = inst[31:25];
  assign is_imm    = (opcode == OPC_OP_IMM);
  assign f7_base   = (funct7 == F7_BASE);
  assign f7_alt    = (funct7 == F7_ALT);
  assign unused_rd = ^inst[11:7];

  always_comb begin
    ctrl    = '0;
    src_a   = SRC_A_RS1;
    src_b   = SRC_B_RS2;
    imm     = {{20{inst[31]}}, inst[31:20]};
    illegal = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        src_a  = (opcode == OPC_LUI) ? SRC_A_ZERO : SRC_A_PC;
        src_b  = SRC_B_IMM;
        imm    = {inst[31:12], 12'b0};
        ctrl.op_sel[OP_ADD] = 1'b1;
      end
      OPC_OP, OPC_OP_IMM: begin
        if (is_imm) src_b = SRC_B_IMM;
        case (funct3)
          3'b000: begin
            ctrl.op_sel[OP_ADD] = 1'b1;
            ctrl.sub = !is_imm && funct7[5];
            illegal  = !is_imm && !(f7_base || f7_alt);
          end
          3'b001, 3'b101: begin
            // The alternate funct7 is only an arithmetic right shift in register form.
            ctrl.op_sel[OP_SHIFT] = 1'b1;
            ctrl.shift_dir = funct3[2];
            ctrl.sub       = funct7[5];
            illegal = !(f7_base || (f7_alt && (is_imm || funct3[2])));
          end
          3'b100, 3'b110, 3'b111: begin
            ctrl.op_sel[OP_BOOL] = 1'b1;
            ctrl.bool_op = (funct3 == 3'b100) ? BOOL_XOR :
                           (funct3 == 3'b110) ? BOOL_OR  : BOOL_AND;
            illegal = !is_imm && !f7_base;
          end
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) ctrl = '0;
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode stage with registered valid/ready output; DECODE_WB_BYPASS_EN adds writeback bypass
module decode_stage
  import risky_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc,
  input  logic        i_flush,
  output logic [4:0]  o_rs1_addr,
  output logic [4:0]  o_rs2_addr,
  input  logic [31:0] i_rs1_data,
  input  logic [31:0] i_rs2_data,
  input  logic        i_wb_en,
  input  logic [4:0]  i_wb_addr,
  input  logic [31:0] i_wb_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_op_a,
  output logic [31:0] o_op_b,
  output logic        o_sub,
  output logic [1:0]  o_bool_op,
  output logic [3:0]  o_op_sel,
  output logic        o_shift_dir,
  output logic [4:0]  o_rd_addr,
  output logic        o_rd_wen,
  output logic        o_illegal
);

  alu_ctrl_t   ctrl_d;
  alu_ctrl_t   ctrl_q;
  src_a_t      src_a;
  src_b_t      src_b;
  logic [31:0] imm;
  logic        illegal_d;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] op_a_d;
  logic [31:0] op_b_d;
  logic        rd_wen_d;
  logic        accept;

  decode_alu_ctrl u_alu_ctrl (
    .inst    (i_inst),
    .ctrl    (ctrl_d),
    .src_a   (src_a),
    .src_b   (src_b),
    .imm     (imm),
    .illegal (illegal_d)
  );

  assign o_rs1_addr = i_inst[19:15];
  assign o_rs2_addr = i_inst[24:20];
  assign o_ready    = !o_valid || i_ready;
  assign accept     = i_valid && o_ready;
  assign rd_wen_d   = !illegal_d && (i_inst[11:7] != 5'd0);

`ifdef DECODE_WB_BYPASS_EN
  assign rs1_val = (i_wb_en && i_wb_addr != 5'd0 && i_wb_addr == o_rs1_addr) ? i_wb_data : i_rs1_data;
  assign rs2_val = (i_wb_en && i_wb_addr != 5'd0 && i_wb_addr == o_rs2_addr) ? i_wb_data : i_rs2_data;
`else
  logic unused_wb;
  assign unused_wb = ^{i_wb_en, i_wb_addr, i_wb_data};
  assign rs1_val   = i_rs1_data;
  assign rs2_val   = i_rs2_data;
`endif

  always_comb begin
    op_a_d = rs1_val;
    case (src_a)
      SRC_A_ZERO: op_a_d = '0;
      SRC_A_PC:   op_a_d = i_pc;
      default:    op_a_d = rs1_val;
    endcase
    op_b_d = (src_b == SRC_B_IMM) ? imm : rs2_val;
    // Mask after bypass so a forwarded value can never set shift amount bit 5.
    if (ctrl_d.op_sel[OP_SHIFT]) op_b_d = {27'b0, op_b_d[4:0]};
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_valid   <= 1'b0;
      o_op_a    <= '0;
      o_op_b    <= '0;
      ctrl_q    <= '0;
      o_rd_addr <= '0;
      o_rd_wen  <= 1'b0;
      o_illegal <= 1'b0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
    end else if (accept) begin
      o_valid   <= 1'b1;
      o_op_a    <= op_a_d;
      o_op_b    <= op_b_d;
      ctrl_q    <= ctrl_d;
      o_rd_addr <= i_inst[11:7];
      o_rd_wen  <= rd_wen_d;
      o_illegal <= illegal_d;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

  assign o_sub       = ctrl_q.sub;
  assign o_bool_op   = ctrl_q.bool_op;
  assign o_op_sel    = ctrl_q.op_sel;
  assign o_shift_dir = ctrl_q.shift_dir;

endmodule
